// File: rtl/icache_frontend.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-word fill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_frontend #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {StIdle, StFetch} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS];

  logic [29:0] fill_addr_q, fill_addr_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             fill_we;
  logic             unused_addr;

  assign req_idx     = imemaddr[2+IDX_W-1:2];
  assign req_tag     = imemaddr[31:2+IDX_W];
  assign fill_idx    = fill_addr_q[IDX_W-1:0];
  assign fill_tag    = fill_addr_q[29:IDX_W];
  assign unused_addr = ^imemaddr[1:0];

  assign hit = (state_q == StIdle) && imemREN && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  // State drops to idle asynchronously on reset, so a pending fill never writes.
  assign fill_we = (state_q == StFetch) && !iwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    unique case (state_q)
      StIdle: begin
        if (imemREN && !hit) begin
          state_d     = StFetch;
          fill_addr_d = imemaddr[31:2];
        end
      end
      StFetch: begin
        if (!iwait) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    unique case (state_q)
      StIdle: begin
        ihit     = hit;
        imemload = hit ? data_q[req_idx] : '0;
      end
      StFetch: begin
        iREN  = 1'b1;
        iaddr = {fill_addr_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        miss_evt;

  assign miss_evt = (state_q == StIdle) && (state_d == StFetch);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_frontend.sv
// Directed bench for icache_frontend: cold miss, hit, conflict, squash, reset mid-fill.
module tb_icache_frontend;

  logic        CLK;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_frontend dut (
    .CLK       (CLK),
    .RST       (RST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    #2;
    check_eq("rst_ihit", {31'd0, ihit}, 32'd0);
    check_eq("rst_iren", {31'd0, iREN}, 32'd0);
    check_eq("rst_iaddr", iaddr, 32'd0);
    check_eq("rst_imemload", imemload, 32'd0);
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);

    cyc();
    RST = 1'b0;

    // Cold miss on 0x40, three wait cycles then data
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    check_eq("cold_idle_ihit", {31'd0, ihit}, 32'd0);
    check_eq("cold_idle_iren", {31'd0, iREN}, 32'd0);
    check_eq("cold_idle_load", imemload, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        iwait = 1'b0;
        iload = 32'h2001_000A;
      end
      #1;
      check_eq("cold_fetch_iren", {31'd0, iREN}, 32'd1);
      check_eq("cold_fetch_iaddr", iaddr, 32'h0000_0040);
      check_eq("cold_fetch_ihit", {31'd0, ihit}, 32'd0);
    end
    cyc();
    iwait = 1'b1;
    #1;
    check_eq("cold_after_ihit", {31'd0, ihit}, 32'd1);
    check_eq("cold_after_load", imemload, 32'h2001_000A);
    check_eq("cold_after_iren", {31'd0, iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
    check_eq("cold_miss_count", miss_count, 32'd1);
    check_eq("cold_hit_count", hit_count, 32'd0);
`endif

    // Hit again on the next cycle
    cyc();
    check_eq("hit_ihit", {31'd0, ihit}, 32'd1);
    check_eq("hit_load", imemload, 32'h2001_000A);
    check_eq("hit_iren", {31'd0, iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
    check_eq("hit_hit_count", hit_count, 32'd1);
`else
    check_eq("hit_count_tied", hit_count, 32'd0);
    check_eq("miss_count_tied", miss_count, 32'd0);
`endif

    // Conflict: 0x80 shares index 0 with 0x40
    imemaddr = 32'h0000_0080;
    #1;
    check_eq("conflict_miss", {31'd0, ihit}, 32'd0);
    cyc();
    check_eq("conflict_iaddr", iaddr, 32'h0000_0080);
    iwait = 1'b0;
    iload = 32'h8C22_0000;
    cyc();
    iwait = 1'b1;
    #1;
    check_eq("conflict_ihit", {31'd0, ihit}, 32'd1);
    check_eq("conflict_load", imemload, 32'h8C22_0000);
    imemaddr = 32'h0000_0040;
    #1;
    check_eq("evicted_miss", {31'd0, ihit}, 32'd0);
    cyc();
    check_eq("evicted_iaddr", iaddr, 32'h0000_0040);
    iwait = 1'b0;
    iload = 32'h2001_000A;
    cyc();
    iwait   = 1'b1;
    imemREN = 1'b0;

    // Squash: request 0x100, redirect during fetch
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    #1;
    check_eq("squash_miss", {31'd0, ihit}, 32'd0);
    cyc();
    imemaddr = 32'h0000_0200;
    imemREN  = 1'b0;
    #1;
    check_eq("squash_iaddr", iaddr, 32'h0000_0100);
    cyc();
    iwait = 1'b0;
    iload = 32'h1111_1111;
    cyc();
    iwait = 1'b1;
    #1;
    check_eq("squash_idle_iren", {31'd0, iREN}, 32'd0);
    check_eq("squash_idle_ihit", {31'd0, ihit}, 32'd0);
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    #1;
    check_eq("squash_frame_ihit", {31'd0, ihit}, 32'd1);
    check_eq("squash_frame_load", imemload, 32'h1111_1111);
    imemaddr = 32'h0000_0200;
    #1;
    check_eq("squash_200_miss", {31'd0, ihit}, 32'd0);
    cyc();
    check_eq("squash_200_iren", {31'd0, iREN}, 32'd1);
    check_eq("squash_200_iaddr", iaddr, 32'h0000_0200);

    // Reset asserted mid-fill
    RST = 1'b1;
    #1;
    check_eq("rstfill_iren", {31'd0, iREN}, 32'd0);
    check_eq("rstfill_iaddr", iaddr, 32'd0);
    cyc();
    RST      = 1'b0;
    imemaddr = 32'h0000_0100;
    #1;
    check_eq("post_rst_miss", {31'd0, ihit}, 32'd0);
    cyc();
    check_eq("post_rst_iren", {31'd0, iREN}, 32'd1);
    check_eq("post_rst_iaddr", iaddr, 32'h0000_0100);
    iwait = 1'b0;
    iload = 32'h1111_1111;
    cyc();
    iwait = 1'b1;
    #1;
    check_eq("post_rst_hit", {31'd0, ihit}, 32'd1);

`ifdef ICACHE_STATS_EN
    // Saturation: preload counter, then let a hit occur
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_cnt_q;
    cyc();
    check_eq("sat_hit_count", hit_count, 32'hFFFF_FFFF);
`endif

    imemREN = 1'b0;
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
